// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states, opcode/cmd fields, ALU ops, condition codes.
// MULTICYCLE_CTRL_CMP_EN: when defined, cmd 1010 (CMP) decodes as a flag-setting subtract.
package ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  typedef enum logic [3:0] {
    FETCH  = S_FETCH,
    DECODE = S_DECODE,
    MEMADR = S_MEMADR,
    MEMRD  = S_MEMRD,
    MEMWB  = S_MEMWB,
    MEMWR  = S_MEMWR,
    EXECR  = S_EXECR,
    EXECI  = S_EXECI,
    ALUWB  = S_ALUWB,
    BRANCH = S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

`ifdef MULTICYCLE_CTRL_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  // nop: no register write, no flag write. cmp: no register write, flags written regardless of S.
  typedef struct packed {
    logic [1:0] alu;
    logic       nop;
    logic       cmp;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d = '{alu: ALU_ADD, nop: 1'b0, cmp: 1'b0};
    case (cmd)
      CMD_ADD: d.alu = ALU_ADD;
      CMD_SUB: d.alu = ALU_SUB;
      CMD_AND: d.alu = ALU_AND;
      CMD_ORR: d.alu = ALU_ORR;
      CMD_CMP: begin
        d.alu = CMP_EN ? ALU_SUB : ALU_ADD;
        d.cmp = CMP_EN;
        d.nop = !CMP_EN;
      end
      default: d.nop = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Architectural NZCV register, condition-code evaluation and the per-instruction condition latch.
module cond_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic       flag_en,
  input  logic       cv_en,
  output logic [3:0] flags,
  output logic       cond_ex_q
);

  logic cond_ex;
  assign cond_ex = cond_holds(cond, flags);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= FLAGS_RESET;
      cond_ex_q <= 1'b0;
    end else begin
      if (cond_latch) cond_ex_q <= cond_ex;
      // Logical ops leave C and V untouched.
      if (flag_en && cond_ex_q) begin
        flags[3:2] <= alu_flags[3:2];
        if (cv_en) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control FSM and datapath control decode.
// MULTICYCLE_CTRL_CMP_EN (see ctrl_pkg) enables the CMP command.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] flags
);

  state_t   state;
  cmd_dec_t dec;
  logic     i_bit, s_bit, l_bit;
  logic     cond_ex_q;
  logic     exec_state;
  logic     wb_ok;

  assign i_bit = funct[5];
  assign s_bit = funct[0];
  assign l_bit = funct[0];
  assign dec   = decode_cmd(funct[4:1]);

  assign exec_state = (state == EXECR) || (state == EXECI);
  // nop/cmp only mean something for data-processing; memory writebacks are gated by the condition alone.
  assign wb_ok = cond_ex_q && !((op == OP_DP) && (dec.nop || dec.cmp));

  cond_unit #(.FLAGS_RESET(FLAGS_RESET)) u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .cond_latch(state == DECODE),
    .flag_en   (exec_state && !dec.nop && (s_bit || dec.cmp)),
    .cv_en     ((dec.alu == ALU_ADD) || (dec.alu == ALU_SUB)),
    .flags     (flags),
    .cond_ex_q (cond_ex_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (op)
            OP_MEM:  state <= MEMADR;
            OP_DP:   state <= i_bit ? EXECI : EXECR;
            OP_BR:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= l_bit ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        EXECR,
        EXECI:  state <= ALUWB;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs decode straight from the state register: reset must force FETCH selects immediately and
  // ir_write must be live on the very first cycle after release, which a registered copy cannot give.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_write   = 1'b1;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      MEMADR: alu_src_b = SRCB_IMM;
      MEMRD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = wb_ok;
        pc_write   = wb_ok && (rd == 4'd15);
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex_q;
      end
      EXECR: begin
        alu_src_b   = SRCB_REG;
        alu_control = dec.alu;
      end
      EXECI: begin
        alu_src_b   = SRCB_IMM;
        alu_control = dec.alu;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = wb_ok;
        pc_write   = wb_ok && (rd == 4'd15);
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = cond_ex_q;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign imm_src = op;
  assign reg_src = {(op == OP_MEM) && !l_bit, op == OP_BR};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions, mid-instruction reset, then random instructions
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd), .alu_flags(alu_flags),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src), .flags(flags)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  assign dut_vec = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                    alu_src_b, alu_control, imm_src, reg_src, flags};

  // Instruction phases as the programmer's model sees them.
  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXECR, P_EXECI, P_ALUWB, P_BRANCH} phase_t;

  typedef struct packed {
    logic [1:0] alu;
    bit         wb;
    bit         fl_ok;
    bit         fl_force;
  } mcmd_t;

  logic [3:0] m_flags;
  bit         m_cond_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic mcmd_t m_cmd(input logic [3:0] c);
    case (c)
      4'b0100: return '{alu: 2'b00, wb: 1, fl_ok: 1, fl_force: 0};
      4'b0010: return '{alu: 2'b01, wb: 1, fl_ok: 1, fl_force: 0};
      4'b0000: return '{alu: 2'b10, wb: 1, fl_ok: 1, fl_force: 0};
      4'b1100: return '{alu: 2'b11, wb: 1, fl_ok: 1, fl_force: 0};
`ifdef MULTICYCLE_CTRL_CMP_EN
      4'b1010: return '{alu: 2'b01, wb: 0, fl_ok: 1, fl_force: 1};
`endif
      default: return '{alu: 2'b00, wb: 0, fl_ok: 0, fl_force: 0};
    endcase
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Expected output vector for the current instruction in a given phase.
  function automatic logic [19:0] expect_vec(input phase_t ph, input bit in_reset);
    logic pcw, adr, mw, irw, rw, a;
    logic [1:0] res, b, alu;
    mcmd_t mc;
    bit wb_ok;
    mc = m_cmd(funct[4:1]);
    wb_ok = m_cond_ok && (op != 2'b00 || mc.wb);
    {pcw, adr, mw, irw, rw, a} = '0;
    res = 2'b00; b = 2'b00; alu = 2'b00;
    case (ph)
      P_FETCH:  begin irw = 1; pcw = 1; a = 1; b = 2'b10; res = 2'b10; end
      P_DECODE: begin a = 1; b = 2'b10; res = 2'b10; end
      P_MEMADR: b = 2'b01;
      P_MEMRD:  adr = 1;
      P_MEMWB:  begin res = 2'b01; rw = wb_ok; pcw = wb_ok && rd == 15; end
      P_MEMWR:  begin adr = 1; mw = m_cond_ok; end
      P_EXECR:  alu = mc.alu;
      P_EXECI:  begin b = 2'b01; alu = mc.alu; end
      P_ALUWB:  begin rw = wb_ok; pcw = wb_ok && rd == 15; end
      P_BRANCH: begin b = 2'b01; res = 2'b10; pcw = m_cond_ok; end
      default: ;
    endcase
    if (in_reset) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    return {pcw, adr, mw, irw, rw, res, a, b, alu, op, {op == 2'b01 && !funct[0], op == 2'b10}, m_flags};
  endfunction

  // One cycle: drive alu_flags, check at negedge, then advance the model across the posedge.
  task automatic step(input phase_t ph, input bit fixed_af, input logic [3:0] af, input string tag);
    mcmd_t mc;
    alu_flags = fixed_af ? af : 4'($urandom);
    @(negedge clk);
    check($sformatf("%s/%s", tag, ph.name()), {12'h0, dut_vec}, {12'h0, expect_vec(ph, 1'b0)});
    @(posedge clk);
    mc = m_cmd(funct[4:1]);
    if (ph == P_DECODE) m_cond_ok = m_cond(cond, m_flags);
    if ((ph == P_EXECR || ph == P_EXECI) && m_cond_ok && mc.fl_ok && (funct[0] || mc.fl_force)) begin
      m_flags[3:2] = alu_flags[3:2];
      if (mc.alu == 2'b00 || mc.alu == 2'b01) m_flags[1:0] = alu_flags[1:0];
    end
    #1;
  endtask

  task automatic set_instr(input logic [31:0] instr);
    cond  = instr[31:28];
    op    = instr[27:26];
    funct = instr[25:20];
    rd    = instr[15:12];
  endtask

  task automatic run_instr(input logic [31:0] instr, input bit fixed_af, input logic [3:0] af, input string tag);
    phase_t ph[$];
    set_instr(instr);
    ph = '{P_FETCH, P_DECODE};
    case (instr[27:26])
      2'b01: begin
        ph.push_back(P_MEMADR);
        if (instr[20]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
        else ph.push_back(P_MEMWR);
      end
      2'b00: begin ph.push_back(instr[25] ? P_EXECI : P_EXECR); ph.push_back(P_ALUWB); end
      2'b10: ph.push_back(P_BRANCH);
      default: ;
    endcase
    foreach (ph[k]) step(ph[k], fixed_af, af, tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] c, r;
    logic [1:0] o;
    logic [5:0] f;
    logic [3:0] cmds [5];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    c = ($urandom_range(1) == 1) ? 4'b1110 : 4'($urandom);
    o = 2'($urandom);
    f = 6'($urandom);
    if (o == 2'b00 && $urandom_range(3) != 0) f[4:1] = cmds[$urandom_range(4)];
    r = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom);
    return {c, o, f, 4'h0, r, 12'h000};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_instr(32'h0);
    alu_flags = 4'h0;
    m_flags = 4'b0000;
    m_cond_ok = 0;
    #12;
    check("reset_state", {12'h0, dut_vec}, {12'h0, expect_vec(P_FETCH, 1'b1)});
    @(posedge clk); #1 reset = 1'b0;

    run_instr(32'hE0821003, 0, 4'h0, "add");
    check("add_flags", {28'h0, flags}, 32'h0);
    run_instr(32'hE5921004, 0, 4'h0, "ldr");
    run_instr(32'hE5821004, 0, 4'h0, "str");
    run_instr(32'hE0510001, 1, 4'b0100, "subs_z");
    check("subs_flags", {28'h0, flags}, 32'h4);
    run_instr(32'h0A000002, 0, 4'h0, "beq_taken");
    run_instr(32'hE0510001, 1, 4'b0000, "subs_nz");
    check("subs_flags_clear", {28'h0, flags}, 32'h0);
    run_instr(32'h0A000002, 0, 4'h0, "beq_not_taken");

    for (int i = 0; i < 150; i++) run_instr(rand_instr(), 0, 4'h0, $sformatf("rnd%0d", i));

    // Reset asserted mid-LDR while in MEMRD.
    set_instr(32'hE5921004);
    step(P_FETCH, 0, 4'h0, "rst_ldr");
    step(P_DECODE, 0, 4'h0, "rst_ldr");
    step(P_MEMADR, 0, 4'h0, "rst_ldr");
    #2 reset = 1'b1;
    m_flags = 4'b0000;
    m_cond_ok = 0;
    #1;
    check("reset_async", {12'h0, dut_vec}, {12'h0, expect_vec(P_FETCH, 1'b1)});
    @(negedge clk);
    check("reset_hold", {12'h0, dut_vec}, {12'h0, expect_vec(P_FETCH, 1'b1)});
    @(posedge clk); #1;
    check("reset_after_edge", {12'h0, dut_vec}, {12'h0, expect_vec(P_FETCH, 1'b1)});
    reset = 1'b0;
    #1;
    check("post_reset_ir_write", {31'h0, ir_write}, 32'h1);
    check("post_reset_fetch", {12'h0, dut_vec}, {12'h0, expect_vec(P_FETCH, 1'b0)});

    for (int i = 0; i < 50; i++) run_instr(rand_instr(), 0, 4'h0, $sformatf("post%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit and sequencer for the multicycle variant of the ARM-subset datapath.
- Decodes the latched instruction fields cond, op, funct and rd.
- Keeps the architectural NZCV flags and evaluates the condition code.
- Drives every datapath mux select and write enable, one state per cycle.
- Sits beside the datapath; the datapath's alu_flags output feeds this block.

Parameters:
- FLAGS_RESET, 4'b0000, reset value of the NZCV register ({N,Z,C,V}).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- cond  in  4  instr[31:28].
- op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- funct  in  6  instr[25:20]. DP: [5]=I, [4:1]=cmd, [0]=S. MEM: [5]=~I, [0]=L.
- rd  in  4  instr[15:12].
- alu_flags  in  4  {N,Z,C,V} of the current ALU result.
- pc_write  out  1  PC load enable.
- adr_src  out  1  0 selects PC as memory address, 1 selects the ALU-out register.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write enable.
- result_src  out  2  00 ALU-out register, 01 read data, 10 ALU result.
- alu_src_a  out  1  0 selects register A, 1 selects PC.
- alu_src_b  out  2  00 register B, 01 ext_imm, 10 constant 4.
- alu_control  out  2  00 add, 01 sub, 10 and, 11 orr.
- imm_src  out  2  equal to op.
- reg_src  out  2  [0]=(op==10); [1]=(op==01 & ~L).
- flags  out  4  current NZCV register.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. One transition per clk.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op 01 -> MEMADR; op 00 with I=1 -> EXECI; op 00 with I=0 -> EXECR; op 10 -> BRANCH; op 11 -> FETCH.
  - MEMADR -> MEMRD if L=1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECR/EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
- Per-state outputs; any field not listed is 0:
  - FETCH: adr_src 0, ir_write 1, alu_src_a 1, alu_src_b 10, add, result_src 10, pc_write 1.
  - DECODE: alu_src_a 1, alu_src_b 10, add, result_src 10.
  - MEMADR: alu_src_a 0, alu_src_b 01, add.
  - MEMRD: adr_src 1.
  - MEMWB: result_src 01, reg_write gated.
  - MEMWR: adr_src 1, mem_write gated.
  - EXECR: alu_src_b 00, alu_control from cmd.
  - EXECI: alu_src_b 01, alu_control from cmd.
  - ALUWB: result_src 00, reg_write gated.
  - BRANCH: alu_src_a 0, alu_src_b 01, add, result_src 10, pc_write gated.
- cmd decode: 0100 add, 0010 sub, 0000 and, 1100 orr. Any other cmd gives add with reg_write and flag write suppressed (NOP).
- Conditions (N,Z,C,V from flags):
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 evaluates to 0.
- Condition latch: cond_ex_q is registered on the DECODE->next edge. All gating uses cond_ex_q, never the live condition.
- Gating:
  - Gated reg_write = state enable & cond_ex_q & ~nop.
  - Gated mem_write = enable & cond_ex_q.
  - BRANCH pc_write = cond_ex_q.
  - In MEMWB/ALUWB with rd==15 and a gated write: pc_write also asserts.
- Flags update on the EXECR/EXECI->ALUWB edge when S & cond_ex_q & ~nop:
  - N,Z always update.
  - C,V update only for add/sub.
  - and/orr keep C,V.
- Reset, asynchronous, at any time including mid-instruction:
  - state=FETCH, flags=FLAGS_RESET, cond_ex_q=0.
  - While reset is high, pc_write, ir_write, reg_write and mem_write are 0; the other outputs hold FETCH values.
  - First FETCH cycle follows reset release.

Optional Feature:
- MULTICYCLE_CTRL_CMP_EN defined: cmd 1010 (CMP) decodes as sub.
  - Flags NZCV are written when cond_ex_q, regardless of S.
  - reg_write is always suppressed.
  - The sequence still visits ALUWB.
- Undefined: cmd 1010 is an ordinary NOP cmd.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding localparams (4-bit);
  - OP_DP/OP_MEM/OP_BR;
  - cmd codes;
  - ALU_ADD/SUB/AND/ORR;
  - the 16 condition codes.
- Sub-module cond_unit: NZCV register, condition evaluation, cond_ex_q flop and flag write gating.
- The FSM and output decode stay in multicycle_ctrl.

Test Plan:
- ADD R1,R2,R3 (0xE0821003), flags 0:
  - States are FETCH, DECODE, EXECR, ALUWB, FETCH.
  - alu_control 00; reg_write=1 only in ALUWB; flags stay 0000.
- LDR R1,[R2,#4] (0xE5921004):
  - States are FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - adr_src=1 in MEMRD; result_src=01 and reg_write=1 in MEMWB; imm_src=01.
- STR R1,[R2,#4] (0xE5821004):
  - MEMWR with mem_write=1 and reg_src=10.
  - reg_write is never 1 during the instruction.
- SUBS R0,R1,R1 (0xE0510001), alu_flags=0100 in EXECR: flags=0100 after ALUWB.
- BEQ (0x0A000002) after the SUBS case: pc_write=1 in BRANCH.
- BEQ with flags=0000: pc_write=0 in BRANCH.
- reset asserted during MEMRD of the LDR:
  - state=FETCH immediately; all write enables are 0 while reset is high; flags=0000.
  - After release, ir_write=1 on the first cycle.
